// File: rtl/hatch_ctrl.sv
// Incubation sequencer: times hatch stages while the temperature switch reads in range,
// and handles pause, fail and done conditions for the dot-matrix display path.
module hatch_ctrl #(
  parameter int STAGE_MS = 1000,
  parameter int STAGES   = 12,
  parameter int FAIL_MS  = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       st,
  input  logic       temp_ok,
  output logic [3:0] num,
  output logic       temp,
  output logic       running,
  output logic       done,
  output logic       fail,
  output logic       stage_tick
);

  localparam int MS_W  = (STAGE_MS > 1) ? $clog2(STAGE_MS) : 1;
  localparam int BAD_W = (FAIL_MS > 1) ? $clog2(FAIL_MS) : 1;

  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(STAGE_MS - 1);
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(FAIL_MS - 1);
  localparam logic [3:0]       NUM_LAST = 4'(STAGES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INC   = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;

  logic [1:0]       st_sync_q, st_sync_d;
  logic [1:0]       ok_sync_q, ok_sync_d;
  logic             st_s, ok_s;
  logic [2:0]       state_q, state_d;
  logic [3:0]       num_q, num_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic [BAD_W-1:0] bad_q, bad_d;
  logic             tick_q, tick_d;
  logic             temp_q, temp_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;

  assign st_s = st_sync_q[1];
  assign ok_s = ok_sync_q[1];

  // NOTE: combinational next-state logic uses blocking assignments with a default for
  // every target first, so no latch can be inferred on any path.
  always_comb begin
    st_sync_d = {st_sync_q[0], st};
    ok_sync_d = {ok_sync_q[0], temp_ok};
    state_d   = state_q;
    num_d     = num_q;
    ms_d      = ms_q;
    bad_d     = bad_q;
    tick_d    = 1'b0;

    if (!st_s) begin
      state_d = S_IDLE;
      num_d   = '0;
      ms_d    = '0;
      bad_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          num_d   = '0;
          ms_d    = '0;
          bad_d   = '0;
          state_d = ok_s ? S_INC : S_PAUSE;
        end
        S_INC: begin
          bad_d = '0;
          // The wrap advance wins over a simultaneous temperature drop.
          if (ms_q == MS_LAST) begin
            ms_d   = '0;
            num_d  = num_q + 4'd1;
            tick_d = 1'b1;
            if (num_d == NUM_LAST) state_d = S_DONE;
            else if (!ok_s)        state_d = S_PAUSE;
          end else if (!ok_s) begin
            state_d = S_PAUSE;
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (ok_s) begin
            state_d = S_INC;
            bad_d   = '0;
          end else if (bad_q == BAD_LAST) begin
            state_d = S_FAIL;
          end else begin
            bad_d = bad_q + 1'b1;
          end
        end
        S_DONE, S_FAIL: state_d = state_q;
        default:        state_d = S_IDLE;
      endcase
    end

    // Flags are decoded from the next state so they update on the same edge as state.
    temp_d    = (state_d == S_PAUSE) || (state_d == S_FAIL);
    running_d = (state_d == S_INC) || (state_d == S_PAUSE);
    done_d    = (state_d == S_DONE);
    fail_d    = (state_d == S_FAIL);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_sync_q <= '0;
      ok_sync_q <= '0;
      state_q   <= S_IDLE;
      num_q     <= '0;
      ms_q      <= '0;
      bad_q     <= '0;
      tick_q    <= 1'b0;
      temp_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      st_sync_q <= st_sync_d;
      ok_sync_q <= ok_sync_d;
      state_q   <= state_d;
      num_q     <= num_d;
      ms_q      <= ms_d;
      bad_q     <= bad_d;
      tick_q    <= tick_d;
      temp_q    <= temp_d;
      running_q <= running_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  assign num        = num_q;
  assign temp       = temp_q;
  assign running    = running_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign stage_tick = tick_q;

endmodule
